// File: rtl/colour_scan_ctrl.sv
// ============================================================================
// Module      : colour_scan_ctrl
// Description : Frame-level sequencer for the colour_detect pixel classifier.
//               Steps the classifier through RED, GREEN and BLUE on successive
//               frames (aligned to sop), latches each frame's pixel total and
//               publishes the dominant colour every third frame.
//               Optional macro COLOUR_SCAN_HYST_EN: dominant/target_found only
//               update when two consecutive decisions agree.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module colour_scan_ctrl #(
  parameter int         PIX_W          = 17,
  parameter int         MIN_PIXELS     = 500,
  parameter logic [3:0] DEFAULT_THRESH = 4'h8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sop,
  input  logic [PIX_W-1:0] colour_pixels,
  input  logic [3:0]       thresh_cfg,
  output logic [1:0]       colour,
  output logic [3:0]       upper_thresh,
  output logic [PIX_W-1:0] red_count,
  output logic [PIX_W-1:0] green_count,
  output logic [PIX_W-1:0] blue_count,
  output logic [1:0]       dominant,
  output logic             target_found,
  output logic             result_valid,
  output logic             busy
);

  localparam logic [PIX_W-1:0] c_MIN_PIX = PIX_W'(MIN_PIXELS);

  localparam logic [1:0] c_COL_RED   = 2'b00;
  localparam logic [1:0] c_COL_GREEN = 2'b01;
  localparam logic [1:0] c_COL_BLUE  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN_R = 3'd1,
    ST_SCAN_G = 3'd2,
    ST_SCAN_B = 3'd3,
    ST_DECIDE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_colour;
  logic [1:0]       w_colour_nxt;
  logic [3:0]       r_upper_thresh;
  logic [PIX_W-1:0] r_red;
  logic [PIX_W-1:0] r_green;
  logic [PIX_W-1:0] r_blue;
  logic [1:0]       r_dominant;
  logic             r_found;
  logic             r_result_valid;
  logic             w_lat_r;
  logic             w_lat_g;
  logic             w_lat_b;
  logic [1:0]       w_cand_dom;
  logic             w_cand_found;
  logic [PIX_W-1:0] w_max;
  logic             w_publish;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, colour select and count-latch decode
  always_comb begin
    w_state_nxt  = r_state;
    w_colour_nxt = r_colour;
    w_lat_r      = 1'b0;
    w_lat_g      = 1'b0;
    w_lat_b      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_colour_nxt = c_COL_RED;
        // The frame starting with this sop is the RED frame.
        if (enable && sop) begin
          w_state_nxt = ST_SCAN_R;
        end
      end
      ST_SCAN_R: begin
        // A sop coinciding with an abort still latches the finished frame.
        w_lat_r = sop;
        if (!enable) begin
          w_state_nxt  = ST_IDLE;
          w_colour_nxt = c_COL_RED;
        end else if (sop) begin
          w_state_nxt  = ST_SCAN_G;
          w_colour_nxt = c_COL_GREEN;
        end
      end
      ST_SCAN_G: begin
        w_lat_g = sop;
        if (!enable) begin
          w_state_nxt  = ST_IDLE;
          w_colour_nxt = c_COL_RED;
        end else if (sop) begin
          w_state_nxt  = ST_SCAN_B;
          w_colour_nxt = c_COL_BLUE;
        end
      end
      ST_SCAN_B: begin
        w_lat_b = sop;
        if (!enable) begin
          w_state_nxt  = ST_IDLE;
          w_colour_nxt = c_COL_RED;
        end else if (sop) begin
          w_state_nxt  = ST_DECIDE;
          w_colour_nxt = c_COL_RED;
        end
      end
      ST_DECIDE: begin
        // The frame already in progress is RED, so any sop here is ignored.
        w_colour_nxt = c_COL_RED;
        w_state_nxt  = enable ? ST_SCAN_R : ST_IDLE;
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_colour_nxt = c_COL_RED;
      end
    endcase
  end

  // Colour select and threshold registers; threshold frozen during a scan
  always_ff @(posedge clk) begin
    if (reset) begin
      r_colour       <= c_COL_RED;
      r_upper_thresh <= DEFAULT_THRESH;
    end else begin
      r_colour <= w_colour_nxt;
      if (r_state == ST_IDLE || r_state == ST_DECIDE) begin
        r_upper_thresh <= thresh_cfg;
      end
    end
  end

  // Per-colour frame count latches
  always_ff @(posedge clk) begin
    if (reset) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      if (w_lat_r) r_red   <= colour_pixels;
      if (w_lat_g) r_green <= colour_pixels;
      if (w_lat_b) r_blue  <= colour_pixels;
    end
  end

  // Largest count with RED > GREEN > BLUE tie priority
  always_comb begin
    w_cand_dom = c_COL_RED;
    w_max      = r_red;
    if (r_red >= r_green && r_red >= r_blue) begin
      w_cand_dom = c_COL_RED;
      w_max      = r_red;
    end else if (r_green >= r_blue) begin
      w_cand_dom = c_COL_GREEN;
      w_max      = r_green;
    end else begin
      w_cand_dom = c_COL_BLUE;
      w_max      = r_blue;
    end
    w_cand_found = (w_max >= c_MIN_PIX);
  end

`ifdef COLOUR_SCAN_HYST_EN
  logic [1:0] r_cand_dom;
  logic       r_cand_found;

  // Previous decision, compared against the current one before publishing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand_dom   <= c_COL_RED;
      r_cand_found <= 1'b0;
    end else if (r_state == ST_DECIDE) begin
      r_cand_dom   <= w_cand_dom;
      r_cand_found <= w_cand_found;
    end
  end

  assign w_publish = (w_cand_dom == r_cand_dom) && (w_cand_found == r_cand_found);
`else
  assign w_publish = 1'b1;
`endif

  // Result registers and the one-cycle result_valid pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dominant     <= c_COL_RED;
      r_found        <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= (r_state == ST_DECIDE);
      if (r_state == ST_DECIDE && w_publish) begin
        r_dominant <= w_cand_dom;
        r_found    <= w_cand_found;
      end
    end
  end

  assign colour       = r_colour;
  assign upper_thresh = r_upper_thresh;
  assign red_count    = r_red;
  assign green_count  = r_green;
  assign blue_count   = r_blue;
  assign dominant     = r_dominant;
  assign target_found = r_found;
  assign result_valid = r_result_valid;
  assign busy         = (r_state != ST_IDLE);

endmodule

`default_nettype wire
